// File: rtl/gray_window_pkg.sv
// Shared definitions for the 3x3 grayscale window generator: tap indices,
// row indices of the column registers, coordinate width and the win_out
// packing helper.
package gray_window_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned COORD_W        = 11;
    localparam int unsigned NUM_TAPS       = 9;
    localparam int unsigned NUM_ROWS       = 3;

    // Tap positions inside win_out; NW occupies the MSBs.
    localparam int unsigned TAP_NW = 8;
    localparam int unsigned TAP_N  = 7;
    localparam int unsigned TAP_NE = 6;
    localparam int unsigned TAP_W  = 5;
    localparam int unsigned TAP_C  = 4;
    localparam int unsigned TAP_E  = 3;
    localparam int unsigned TAP_SW = 2;
    localparam int unsigned TAP_S  = 1;
    localparam int unsigned TAP_SE = 0;

    // Row slots of a window column: top is row y-2, bottom is the live row y.
    localparam int unsigned ROW_TOP = 2;
    localparam int unsigned ROW_MID = 1;
    localparam int unsigned ROW_BOT = 0;

    // Bit offset of a tap inside the flattened win_out bus.
    function automatic int unsigned tap_lsb(input int unsigned tap, input int unsigned data_w);
        return tap * data_w;
    endfunction

endpackage

// File: rtl/gray_linebuf_ram.sv
// One line of grayscale history: simple dual-port RAM with a registered
// synchronous read. A read and a write to the same address in one beat
// return the old contents (read-before-write).
module gray_linebuf_ram #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/gray_window_3x3.sv
// Streaming 3x3 neighbourhood generator. Each accepted pixel (x,y) closes the
// window with centre (x-1,y-1), emitted two pclk later together with the
// centre coordinates and a border flag. Taps outside the frame read as 0.
// Optional feature: define GRAY_WINDOW_3X3_LINE_CHECK_EN to add the sticky
// line_err output that flags wrong line lengths.
module gray_window_3x3
    import gray_window_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned X_W      = 10
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic                       pix_valid,
    input  logic [DATA_W-1:0]          pix_in,
    input  logic                       sof,
    input  logic                       eol,
    output logic                       win_valid,
    output logic [NUM_TAPS*DATA_W-1:0] win_out,
    output logic [COORD_W-1:0]         hc_out,
    output logic [COORD_W-1:0]         vc_out,
    output logic                       border
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
    ,
    output logic                       line_err
`endif
);

    localparam int unsigned Y_W = COORD_W;

    // Input-side coordinate counters
    logic [X_W-1:0] x_q, x_d, cur_x;
    logic [Y_W-1:0] y_q, y_d, cur_y, y_adv;
    logic           at_last_col;
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
    logic           err_set;
`endif

    // Stage 1: pixel and coordinates aligned with the RAM read data
    logic              s1_valid;
    logic [DATA_W-1:0] s1_pix;
    logic [X_W-1:0]    s1_x;
    logic [Y_W-1:0]    s1_y;
    logic [DATA_W-1:0] lb0_q, lb1_q;

    // Stage 2: column shift registers and window assembly
    logic [NUM_ROWS-1:0][DATA_W-1:0] col1, col2;
    logic [NUM_ROWS-1:0][DATA_W-1:0] new_col, col1_eff, col2_eff;
    logic [NUM_TAPS-1:0][DATA_W-1:0] win_d;

    // Current pixel position and next counter values; sof restarts at (0,0).
    always_comb begin
        cur_x       = sof ? '0 : x_q;
        cur_y       = sof ? '0 : y_q;
        at_last_col = (cur_x == X_W'(H_ACTIVE - 1));
        y_adv       = (cur_y == Y_W'(V_ACTIVE - 1)) ? cur_y : cur_y + Y_W'(1);
        x_d         = x_q;
        y_d         = y_q;
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
        err_set     = 1'b0;
`endif
        if (pix_valid) begin
            if (eol) begin
                x_d = '0;
                y_d = y_adv;
            end else if (at_last_col) begin
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
                // Overlong line: park on the last column and flag it.
                x_d     = cur_x;
                y_d     = cur_y;
                err_set = 1'b1;
`else
                // Missing eol: wrap as if the line had ended.
                x_d = '0;
                y_d = y_adv;
`endif
            end else begin
                x_d = cur_x + X_W'(1);
                y_d = cur_y;
            end
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
            if (eol && !at_last_col) begin
                err_set = 1'b1;
            end
`endif
        end
    end

    // Coordinate counter registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
    // Sticky line-length error, cleared by the sof beat.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_err <= 1'b0;
        end else if (pix_valid && sof) begin
            line_err <= err_set;
        end else if (err_set) begin
            line_err <= 1'b1;
        end
    end
`endif

    // lb0 holds row y-1; it is read and overwritten with the live pixel in the same beat.
    gray_linebuf_ram #(
        .DEPTH  (H_ACTIVE),
        .DATA_W (DATA_W),
        .ADDR_W (X_W)
    ) u_lb0 (
        .clk   (pclk),
        .rst_n (rst_n),
        .re    (pix_valid),
        .raddr (cur_x),
        .rdata (lb0_q),
        .we    (pix_valid),
        .waddr (cur_x),
        .wdata (pix_in)
    );

    // lb1 holds row y-2; it takes the displaced lb0 word one cycle later, when the read returns.
    gray_linebuf_ram #(
        .DEPTH  (H_ACTIVE),
        .DATA_W (DATA_W),
        .ADDR_W (X_W)
    ) u_lb1 (
        .clk   (pclk),
        .rst_n (rst_n),
        .re    (pix_valid),
        .raddr (cur_x),
        .rdata (lb1_q),
        .we    (s1_valid),
        .waddr (s1_x),
        .wdata (lb0_q)
    );

    // Stage 1 register: carries the pixel alongside the RAM read.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_pix <= pix_in;
                s1_x   <= cur_x;
                s1_y   <= cur_y;
            end
        end
    end

    // Window assembly with out-of-frame masking; column masking at x<2 also
    // hides the previous row's tail after eol or a mid-frame sof.
    always_comb begin
        new_col          = '0;
        new_col[ROW_TOP] = (s1_y < Y_W'(2)) ? '0 : lb1_q;
        new_col[ROW_MID] = (s1_y == '0) ? '0 : lb0_q;
        new_col[ROW_BOT] = s1_pix;
        col1_eff         = (s1_x == '0) ? '0 : col1;
        col2_eff         = (s1_x < X_W'(2)) ? '0 : col2;
        win_d            = '0;
        win_d[TAP_NW]    = col2_eff[ROW_TOP];
        win_d[TAP_N]     = col1_eff[ROW_TOP];
        win_d[TAP_NE]    = new_col[ROW_TOP];
        win_d[TAP_W]     = col2_eff[ROW_MID];
        win_d[TAP_C]     = col1_eff[ROW_MID];
        win_d[TAP_E]     = new_col[ROW_MID];
        win_d[TAP_SW]    = col2_eff[ROW_BOT];
        win_d[TAP_S]     = col1_eff[ROW_BOT];
        win_d[TAP_SE]    = new_col[ROW_BOT];
    end

    // Stage 2 register: column shift and registered window outputs; bubbles hold state.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col1      <= '0;
            col2      <= '0;
            win_valid <= 1'b0;
            win_out   <= '0;
            hc_out    <= '0;
            vc_out    <= '0;
            border    <= 1'b0;
        end else begin
            win_valid <= s1_valid;
            if (s1_valid) begin
                col1    <= new_col;
                col2    <= col1_eff;
                win_out <= win_d;
                hc_out  <= COORD_W'(s1_x) - COORD_W'(1);
                vc_out  <= COORD_W'(s1_y) - COORD_W'(1);
                border  <= (s1_x < X_W'(2)) || (s1_y < Y_W'(2));
            end
        end
    end

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on an 8x4 frame with pix_in = 16*y + x.
// Expected windows come from a coordinate model plus hand-computed constants.
module tb_gray_window_3x3;
    import gray_window_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned XW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          sof = 1'b0;
    logic          eol = 1'b0;
    logic          win_valid;
    logic [9*DW-1:0] win_out;
    logic [10:0]   hc_out, vc_out;
    logic          border;
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
    logic          line_err;
`endif

    gray_window_3x3 #(
        .DATA_W   (DW),
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .X_W      (XW)
    ) dut (
        .pclk      (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .sof       (sof),
        .eol       (eol),
        .win_valid (win_valid),
        .win_out   (win_out),
        .hc_out    (hc_out),
        .vc_out    (vc_out),
        .border    (border)
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
        ,
        .line_err  (line_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [71:0] win;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        brd;
        int unsigned cyc;
        int          x;
        int          y;
    } exp_t;

    exp_t        q[$];
    logic [71:0] cap  [4][8];
    logic        capb [4][8];

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Window whose bottom-right input pixel is (x,y); out-of-frame taps are 0.
    function automatic logic [71:0] model_win(input int x, input int y);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int row;
                int col;
                int tap;
                row = y - 2 + r;
                col = x - 2 + c;
                tap = 8 - (3 * r + c);
                if (row >= 0 && col >= 0) begin
                    w[tap_lsb(tap, DW) +: DW] = 8'(16 * row + col);
                end
            end
        end
        return w;
    endfunction

    task automatic beat(input int x, input int y, input logic s, input logic e);
        exp_t ex;
        pix_valid = 1'b1;
        pix_in    = 8'(16 * y + x);
        sof       = s;
        eol       = e;
        ex.win    = model_win(x, y);
        ex.hc     = (x == 0) ? 11'h7FF : 11'(x - 1);
        ex.vc     = (y == 0) ? 11'h7FF : 11'(y - 1);
        ex.brd    = (x < 2) || (y < 2);
        ex.cyc    = cyc;
        ex.x      = x;
        ex.y      = y;
        q.push_back(ex);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        eol       = 1'b0;
    endtask

    task automatic idle();
        pix_valid = 1'b0;
        pix_in    = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit gaps);
        for (int y = 0; y < int'(V); y++) begin
            for (int x = 0; x < int'(H); x++) begin
                if (gaps && $urandom_range(0, 99) < 30) idle();
                beat(x, y, (x == 0 && y == 0), (x == int'(H) - 1));
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 80'(q.size()), 80'(0));
    endtask

    task automatic clear_cap();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                cap[y][x]  = '1;
                capb[y][x] = 1'bx;
            end
        end
    endtask

    // Scoreboard: every window is matched against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && win_valid) begin
            if (q.size() == 0) begin
                check("spurious_win", 80'(1), 80'(0));
            end else begin
                e = q.pop_front();
                check("win",     80'(win_out), 80'(e.win));
                check("hc",      80'(hc_out),  80'(e.hc));
                check("vc",      80'(vc_out),  80'(e.vc));
                check("border",  80'(border),  80'(e.brd));
                check("latency", 80'(cyc - e.cyc), 80'(2));
                cap[e.y][e.x]  = win_out;
                capb[e.y][e.x] = border;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        clear_cap();
        // Reset held while pixels stream: outputs stay quiet.
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(i + 5);
            sof       = (i == 0);
            @(posedge clk);
            #1;
            check("rst_valid", 80'(win_valid), 80'(0));
            check("rst_win",   80'(win_out),   80'(0));
        end
        check("rst_hc",     80'(hc_out), 80'(0));
        check("rst_vc",     80'(vc_out), 80'(0));
        check("rst_border", 80'(border), 80'(0));
`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
        check("rst_line_err", 80'(line_err), 80'(0));
`endif
        pix_valid = 1'b0;
        sof       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous full frame, interior and border windows.
        frame(1'b0);
        drain("t2_drain");
        check("t2_win_32",    80'(cap[2][3]),  80'(72'h01_02_03_11_12_13_21_22_23));
        check("t2_border_32", 80'(capb[2][3]), 80'(0));
        check("t2_win_73",    80'(cap[3][7]),  80'(72'h15_16_17_25_26_27_35_36_37));
        check("t3_win_11",    80'(cap[1][1]),  80'(72'h00_00_00_00_00_01_00_10_11));
        check("t3_border_11", 80'(capb[1][1]), 80'(1));
        check("t3_win_02",    80'(cap[2][0]),  80'(72'h00_00_00_00_00_10_00_00_20));
        check("t3_border_02", 80'(capb[2][0]), 80'(1));

        // Same frame with idle gaps.
        clear_cap();
        frame(1'b1);
        drain("t4_drain");
        check("t4_win_32", 80'(cap[2][3]), 80'(72'h01_02_03_11_12_13_21_22_23));
        check("t4_win_73", 80'(cap[3][7]), 80'(72'h15_16_17_25_26_27_35_36_37));

        // Mid-frame sof at (5,2): restart without flush.
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < int'(H); x++) begin
                beat(x, y, (x == 0 && y == 0), (x == int'(H) - 1));
            end
        end
        for (int x = 0; x < 5; x++) beat(x, 2, 1'b0, 1'b0);
        clear_cap();
        frame(1'b0);
        drain("t5_drain");
        check("t5_win_10",    80'(cap[0][1]),  80'(72'h00_00_00_00_00_00_00_00_01));
        check("t5_border_10", 80'(capb[0][1]), 80'(1));
        check("t5_win_60",    80'(cap[0][6]),  80'(72'h00_00_00_00_00_00_04_05_06));
        check("t5_win_11",    80'(cap[1][1]),  80'(72'h00_00_00_00_00_01_00_10_11));
        check("t5_win_32",    80'(cap[2][3]),  80'(72'h01_02_03_11_12_13_21_22_23));

`ifdef GRAY_WINDOW_3X3_LINE_CHECK_EN
        // Short line: eol at x=5 sets the sticky error until the next sof.
        check("t6_clear", 80'(line_err), 80'(0));
        for (int x = 0; x < 5; x++) beat(x, 0, (x == 0), 1'b0);
        check("t6_before", 80'(line_err), 80'(0));
        beat(5, 0, 1'b0, 1'b1);
        check("t6_set", 80'(line_err), 80'(1));
        beat(0, 1, 1'b0, 1'b0);
        beat(1, 1, 1'b0, 1'b0);
        check("t6_hold", 80'(line_err), 80'(1));
        beat(0, 0, 1'b1, 1'b0);
        check("t6_sof_clear", 80'(line_err), 80'(0));
        drain("t6_drain");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
